aec_param: RTL and testbench

- Parametrised successor arithmetic expression calculator.
- Receives an infix ASCII expression one character per handshake, terminated by '='.
- Converts it to postfix with a shunting-yard pass, then evaluates it on a value stack.
- Returns a signed DW-bit result with error and overflow status; sits behind the character-stream front end.

---
 rtl/aec_pkg.sv | 65 ++++++
 rtl/aec_if.sv | 23 ++
 rtl/aec_lifo.sv | 51 +++++
 rtl/aec_param.sv | 258 +++++++++++++++++++++++++
 tb/tb_aec_param.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/aec_pkg.sv
// Shared constants, types and character helpers for the expression calculator.
package aec_pkg;

   localparam logic [7:0] CH_LP  = 8'h28;
   localparam logic [7:0] CH_RP  = 8'h29;
   localparam logic [7:0] CH_MUL = 8'h2A;
   localparam logic [7:0] CH_ADD = 8'h2B;
   localparam logic [7:0] CH_SUB = 8'h2D;
   localparam logic [7:0] CH_EQ  = 8'h3D;
   localparam logic [7:0] CH_0   = 8'h30;
   localparam logic [7:0] CH_9   = 8'h39;
   localparam logic [7:0] CH_A   = 8'h61;
   localparam logic [7:0] CH_F   = 8'h66;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_CHAR = 2'd1,
      ERR_OVFL = 2'd2,
      ERR_FORM = 2'd3
   } err_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_CONV,
      S_EVAL,
      S_DONE
   } state_e;

   typedef enum logic [2:0] {
      C_DIGIT,
      C_LP,
      C_RP,
      C_OP,
      C_EQ,
      C_BAD
   } cls_e;

   typedef struct packed {
      logic error;
      err_e code;
      logic ovf;
   } status_t;

   function automatic cls_e char_class(input logic [7:0] c);
      if ((c >= CH_0 && c <= CH_9) || (c >= CH_A && c <= CH_F)) return C_DIGIT;
      if (c == CH_LP) return C_LP;
      if (c == CH_RP) return C_RP;
      if (c == CH_MUL || c == CH_ADD || c == CH_SUB) return C_OP;
      if (c == CH_EQ) return C_EQ;
      return C_BAD;
   endfunction

   function automatic logic [1:0] prec(input logic [7:0] c);
      if (c == CH_MUL) return 2'd2;
      if (c == CH_ADD || c == CH_SUB) return 2'd1;
      return 2'd0;
   endfunction

   // '0'-'9' carry their value in the low nibble; 'a'-'f' sit 9 below theirs.
   function automatic logic [3:0] digit_val(input logic [7:0] c);
      return (c <= CH_9) ? c[3:0] : c[3:0] + 4'd9;
   endfunction

endpackage

// File: rtl/aec_if.sv
// Character-in / result-out bundle between the front end (master) and the calculator (slave).
interface aec_if #(
   parameter int DW = 16
);
   logic          ready;
   logic [7:0]    ascii_in;
   logic          busy;
   logic          valid;
   logic [DW-1:0] result;
   logic          error;
   logic [1:0]    err_code;
   logic          ovf;

   modport master (
      output ready, ascii_in,
      input  busy, valid, result, error, err_code, ovf
   );

   modport slave (
      input  ready, ascii_in,
      output busy, valid, result, error, err_code, ovf
   );
endinterface

// File: rtl/aec_lifo.sv
// Small stack; top is combinational, push+pop in one cycle replaces the top entry.
// Zero latency on top/count; push when full and pop when empty are dropped.
module aec_lifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           top,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    top_ptr;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign wr_ptr  = count[AW-1:0];
   assign top_ptr = wr_ptr - AW'(1);
   assign top     = empty ? '0 : mem[top_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (push && !pop && !full) begin
         count <= count + CW'(1);
      end else if (pop && !push && !empty) begin
         count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && pop && !empty) begin
         mem[top_ptr] <= din;
      end else if (push && !pop && !full) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/aec_param.sv
// Infix ASCII expression calculator: buffer until '=', shunting-yard to postfix, evaluate on a value stack.
// valid within 3*DEPTH+4 cycles of '='; busy refuses characters from the cycle after '=' until back in IDLE.
module aec_param
   import aec_pkg::*;
#(
   parameter int DW     = 16,
   parameter int DEPTH  = 32,
   parameter int SDEPTH = 16
) (
   input logic  clk,
   input logic  rst_n,
   aec_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int VW = $clog2(SDEPTH + 1);

   state_e        state, state_n;
   logic [7:0]    in_buf [DEPTH];
   logic [7:0]    pf_buf [DEPTH];
   logic [IW-1:0] in_cnt, rd_idx, pf_cnt, ev_idx;
   err_e          err_q, err_new, err_fin;
   logic          ovf_q, ovf_new, half_q, half_n;
   logic          b_ld, clr, in_wr, pf_wr, rd_inc, ev_inc, acc, done_ld;
   logic [7:0]    cur, ev, pf_din;
   logic [DW-1:0] b_q, alu, v_din, v_top, result_q;
   logic          alu_ovf, valid_q;
   logic signed [2*DW-1:0] prod;
   status_t       stat_q;

   logic          op_push, op_pop, op_full, op_empty;
   logic [7:0]    op_top;
   logic [VW-1:0] op_cnt;
   logic          v_push, v_pop, v_full, v_empty;
   logic [VW-1:0] v_cnt;

   aec_lifo #(.WIDTH(8), .DEPTH(SDEPTH)) u_op_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (op_push),
      .pop   (op_pop),
      .din   (cur),
      .top   (op_top),
      .count (op_cnt),
      .full  (op_full),
      .empty (op_empty)
   );

   aec_lifo #(.WIDTH(DW), .DEPTH(SDEPTH)) u_val_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (v_push),
      .pop   (v_pop),
      .din   (v_din),
      .top   (v_top),
      .count (v_cnt),
      .full  (v_full),
      .empty (v_empty)
   );

   assign cur          = in_buf[rd_idx];
   assign ev           = pf_buf[ev_idx];
   assign bus.busy     = (state != S_IDLE) && (state != S_RECV);
   assign acc          = bus.ready && !bus.busy;
   assign bus.valid    = valid_q;
   assign bus.result   = result_q;
   assign bus.error    = stat_q.error;
   assign bus.err_code = stat_q.code;
   assign bus.ovf      = stat_q.ovf;

   // a is the value stack top once b has been popped into b_q.
   always_comb begin
      alu     = '0;
      alu_ovf = 1'b0;
      prod    = (2*DW)'($signed(v_top)) * (2*DW)'($signed(b_q));
      case (ev)
         CH_ADD: begin
            alu     = v_top + b_q;
            alu_ovf = (v_top[DW-1] == b_q[DW-1]) && (alu[DW-1] != v_top[DW-1]);
         end
         CH_SUB: begin
            alu     = v_top - b_q;
            alu_ovf = (v_top[DW-1] != b_q[DW-1]) && (alu[DW-1] != v_top[DW-1]);
         end
         CH_MUL: begin
            alu     = prod[DW-1:0];
            alu_ovf = (prod != (2*DW)'($signed(prod[DW-1:0])));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      op_push = 1'b0;
      op_pop  = 1'b0;
      v_push  = 1'b0;
      v_pop   = 1'b0;
      v_din   = alu;
      in_wr   = 1'b0;
      pf_wr   = 1'b0;
      pf_din  = op_top;
      rd_inc  = 1'b0;
      ev_inc  = 1'b0;
      err_new = ERR_NONE;
      ovf_new = 1'b0;
      b_ld    = 1'b0;
      half_n  = half_q;
      clr     = 1'b0;
      case (state)
         S_IDLE, S_RECV: begin
            if (acc) begin
               if (bus.ascii_in == CH_EQ) begin
                  in_wr   = 1'b1;
                  state_n = S_CONV;
               end else begin
                  state_n = S_RECV;
                  if (char_class(bus.ascii_in) == C_BAD) err_new = ERR_CHAR;
                  else if (in_cnt >= IW'(DEPTH - 1))     err_new = ERR_OVFL;
                  else                                   in_wr   = (err_q == ERR_NONE);
               end
            end
         end
         S_CONV: begin
            if (err_q != ERR_NONE) begin
               state_n = S_DONE;
            end else begin
               case (char_class(cur))
                  C_DIGIT: begin
                     pf_wr  = 1'b1;
                     pf_din = cur;
                     rd_inc = 1'b1;
                  end
                  C_LP: begin
                     if (op_full) err_new = ERR_OVFL;
                     else begin op_push = 1'b1; rd_inc = 1'b1; end
                  end
                  C_RP: begin
                     if (op_empty) err_new = ERR_FORM;
                     else begin
                        op_pop = 1'b1;
                        if (op_top == CH_LP) rd_inc = 1'b1;
                        else                 pf_wr  = 1'b1;
                     end
                  end
                  C_OP: begin
                     if (op_cnt != '0 && op_top != CH_LP && prec(op_top) >= prec(cur)) begin
                        op_pop = 1'b1;
                        pf_wr  = 1'b1;
                     end else if (op_full) err_new = ERR_OVFL;
                     else begin op_push = 1'b1; rd_inc = 1'b1; end
                  end
                  C_EQ: begin
                     if (op_empty)              state_n = S_EVAL;
                     else if (op_top == CH_LP)  err_new = ERR_FORM;
                     else begin op_pop = 1'b1; pf_wr = 1'b1; end
                  end
                  default: err_new = ERR_FORM;
               endcase
               if (err_new != ERR_NONE) state_n = S_DONE;
            end
         end
         S_EVAL: begin
            // Operators take two cycles: pop b, then replace a with a op b.
            if (ev_idx == pf_cnt) begin
               if (v_cnt != VW'(1)) err_new = ERR_FORM;
               state_n = S_DONE;
            end else if (char_class(ev) == C_DIGIT) begin
               if (v_full) err_new = ERR_OVFL;
               else begin
                  v_push = 1'b1;
                  v_din  = DW'(digit_val(ev));
                  ev_inc = 1'b1;
               end
            end else if (!half_q) begin
               if (v_empty) err_new = ERR_FORM;
               else begin v_pop = 1'b1; b_ld = 1'b1; half_n = 1'b1; end
            end else begin
               if (v_empty) err_new = ERR_FORM;
               else begin
                  v_push  = 1'b1;
                  v_pop   = 1'b1;
                  ovf_new = alu_ovf;
                  half_n  = 1'b0;
                  ev_inc  = 1'b1;
               end
            end
            if (err_new != ERR_NONE) state_n = S_DONE;
         end
         S_DONE: begin
            state_n = S_IDLE;
            clr     = 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      if (err_q != ERR_NONE) err_fin = err_q;
      else                   err_fin = err_new;
   end

   assign done_ld = (state_n == S_DONE) && (state != S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt   <= '0;
         rd_idx   <= '0;
         pf_cnt   <= '0;
         ev_idx   <= '0;
         err_q    <= ERR_NONE;
         ovf_q    <= 1'b0;
         half_q   <= 1'b0;
         b_q      <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
         stat_q   <= '0;
      end else begin
         if (clr) begin
            in_cnt <= '0;
            rd_idx <= '0;
            pf_cnt <= '0;
            ev_idx <= '0;
            err_q  <= ERR_NONE;
            ovf_q  <= 1'b0;
            half_q <= 1'b0;
         end else begin
            if (in_wr)  in_cnt <= in_cnt + IW'(1);
            if (pf_wr)  pf_cnt <= pf_cnt + IW'(1);
            if (rd_inc) rd_idx <= rd_idx + IW'(1);
            if (ev_inc) ev_idx <= ev_idx + IW'(1);
            if (err_q == ERR_NONE && err_new != ERR_NONE) err_q <= err_new;
            if (ovf_new) ovf_q <= 1'b1;
            half_q <= half_n;
         end
         if (b_ld) b_q <= v_top;
         valid_q <= done_ld;
         if (done_ld) begin
            stat_q.error <= (err_fin != ERR_NONE);
            stat_q.code  <= err_fin;
            stat_q.ovf   <= ovf_q;
            result_q     <= (err_fin != ERR_NONE) ? '0 : v_top;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (in_wr) in_buf[in_cnt] <= bus.ascii_in;
      if (pf_wr) pf_buf[pf_cnt] <= pf_din;
   end

endmodule

// File: tb/tb_aec_param.sv
// Directed bench for aec_param: hand-computed results for valid, error, boundary, busy and reset cases.
module tb_aec_param;
   localparam int DW     = 16;
   localparam int DEPTH  = 32;
   localparam int SDEPTH = 16;
   localparam int LAT    = 3 * DEPTH + 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   aec_if #(.DW(DW)) bus ();

   aec_param #(.DW(DW), .DEPTH(DEPTH), .SDEPTH(SDEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic send_char(input logic [7:0] c);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) chk("busy_wait", 32'(bus.busy), 32'd0);
      bus.ready    = 1'b1;
      bus.ascii_in = c;
      @(posedge clk);
      #1;
      bus.ready = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_char(s[i]);
   endtask

   task automatic wait_valid(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < LAT && !seen; i++) begin
         @(negedge clk);
         seen = bus.valid;
      end
   endtask

   task automatic check_out(input string tag, input logic [31:0] er, input logic [31:0] ee,
                            input logic [31:0] ec, input logic [31:0] eo);
      chk({tag, "_result"}, 32'(bus.result), er);
      chk({tag, "_error"}, 32'(bus.error), ee);
      chk({tag, "_code"}, 32'(bus.err_code), ec);
      chk({tag, "_ovf"}, 32'(bus.ovf), eo);
   endtask

   task automatic run_expr(input string tag, input string s, input logic [31:0] er,
                           input logic [31:0] ee, input logic [31:0] ec, input logic [31:0] eo);
      bit seen;
      send_str(s);
      wait_valid(seen);
      if (!seen) chk({tag, "_valid_seen"}, 32'd0, 32'd1);
      else       check_out(tag, er, ee, ec, eo);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(bus.valid), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      string s;
      bit    seen;
      int    n_valid;
      bus.ready    = 1'b0;
      bus.ascii_in = 8'h00;

      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      check_out("rst", 32'd0, 32'd0, 32'd0, 32'd0);
      rst_n = 1'b1;

      run_expr("prec", "1+2*3=", 32'd7, 32'd0, 32'd0, 32'd0);
      run_expr("paren", "(1+2)*3=", 32'd9, 32'd0, 32'd0, 32'd0);
      run_expr("hexmul", "9-a*0=", 32'd9, 32'd0, 32'd0, 32'd0);
      run_expr("neg", "3-8=", 32'hFFFB, 32'd0, 32'd0, 32'd0);
      run_expr("mulovf", "f*f*f*f=", 32'hC5C1, 32'd0, 32'd0, 32'd1);
      run_expr("openparen", "(1+2=", 32'd0, 32'd1, 32'd3, 32'd0);
      run_expr("badchar", "1+g=", 32'd0, 32'd1, 32'd1, 32'd0);
      run_expr("empty", "=", 32'd0, 32'd1, 32'd3, 32'd0);
      run_expr("closeparen", "2)=", 32'd0, 32'd1, 32'd3, 32'd0);

      s = "";
      repeat (DEPTH + 1) s = {s, "1"};
      run_expr("toolong", {s, "="}, 32'd0, 32'd1, 32'd2, 32'd0);
      run_expr("firstwins", {"g", s, "="}, 32'd0, 32'd1, 32'd1, 32'd0);

      s = "1";
      repeat (15) s = {s, "+1"};
      run_expr("fulllen", {s, "="}, 32'd16, 32'd0, 32'd0, 32'd0);

      s = "";
      repeat (SDEPTH + 1) s = {s, "("};
      run_expr("opstack", {s, "1="}, 32'd0, 32'd1, 32'd2, 32'd0);

      // ready held while busy must not leak a character into the next expression
      send_str("1+2*3=");
      @(negedge clk);
      chk("busy_after_eq", 32'(bus.busy), 32'd1);
      bus.ready    = 1'b1;
      bus.ascii_in = "5";
      repeat (4) @(negedge clk);
      bus.ready = 1'b0;
      wait_valid(seen);
      if (!seen) chk("busyign_valid_seen", 32'd0, 32'd1);
      else       check_out("busyign", 32'd7, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
      run_expr("after_busy", "2=", 32'd2, 32'd0, 32'd0, 32'd0);

      // reset lands in EVAL: 8 CONV cycles precede it for this expression
      send_str("1+2*3=");
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("evrst_valid", 32'(bus.valid), 32'd0);
      chk("evrst_busy", 32'(bus.busy), 32'd0);
      chk("evrst_result", 32'(bus.result), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      n_valid = 0;
      repeat (LAT + 20) begin
         @(negedge clk);
         if (bus.valid) n_valid++;
      end
      chk("evrst_no_valid", 32'(n_valid), 32'd0);
      run_expr("post_rst", "2=", 32'd2, 32'd0, 32'd0, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
